// File: rtl/move_scheduler.sv
// Move scheduler: arbitrates scramble bursts, single-step undo and queued manual
// moves onto the combinational cube engine, one commit per cycle at most.
module move_scheduler #(
    parameter int QDEPTH       = 4,
    parameter int SCRAMBLE_LEN = 20,
    parameter int CNT_MAX      = 999
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       man_valid,
    output logic       man_ready,
    input  logic [2:0] man_face,
    input  logic [1:0] man_rot,
    input  logic       scr_start,
    input  logic [2:0] rnd_face,
    input  logic [1:0] rnd_rot,
    input  logic       undo_req,
    input  logic       hist_empty,
    input  logic       hist_full,
    output logic [5:0] eng_face,
    output logic [2:0] eng_rot,
    output logic       commit,
    output logic       push_hist,
    output logic       pop_hist,
    output logic       clr_hist,
    output logic       verify,
    output logic       busy,
    output logic [9:0] move_count
);

    localparam int AW = $clog2(QDEPTH);
    localparam logic [5:0] SCR_LAST = 6'(SCRAMBLE_LEN - 1);
    localparam logic [9:0] CNT_TOP  = 10'(CNT_MAX);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SCR_INIT = 3'd1;
    localparam logic [2:0] S_SCRAMBLE = 3'd2;
    localparam logic [2:0] S_APPLY    = 3'd3;
    localparam logic [2:0] S_UNDO     = 3'd4;
    localparam logic [2:0] S_VERIFY   = 3'd5;

    // Engine rotation codes: 1 = CW, 2 = double, 3 = CCW, 0 = no move.
    function automatic logic [1:0] map_man(input logic [1:0] r);
        case (r)
            2'b01:   map_man = 2'd1;
            2'b10:   map_man = 2'd3;
            2'b11:   map_man = 2'd2;
            default: map_man = 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] map_rnd(input logic [1:0] r);
        case (r)
            2'd0:    map_rnd = 2'd1;
            2'd1:    map_rnd = 2'd3;
            2'd2:    map_rnd = 2'd2;
            default: map_rnd = 2'd0;
        endcase
    endfunction

    logic [2:0]    state_q, state_d;
    logic [5:0]    scr_cnt_q, scr_cnt_d;
    logic [9:0]    cnt_q, cnt_d;
    logic          undo_pend_q, undo_pend_d;
    logic [AW:0]   wr_q, rd_q;
    logic [4:0]    fifo_q [QDEPTH];
    logic          fifo_full, fifo_empty, wr_en, rd_en;
    logic [4:0]    head;
    logic [1:0]    rnd_map;

    assign fifo_empty = (wr_q == rd_q);
    assign fifo_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign man_ready  = !fifo_full;
    // Null moves are acknowledged but never occupy a slot.
    assign wr_en      = man_valid && man_ready && (man_rot != 2'b00);
    assign rd_en      = (state_q == S_APPLY);
    assign head       = fifo_q[rd_q[AW-1:0]];
    assign rnd_map    = map_rnd(rnd_rot);
    assign busy       = (state_q != S_IDLE);
    assign move_count = cnt_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_q[wr_q[AW-1:0]] <= {man_face, map_man(man_rot)};
        end
    end

    always_comb begin
        state_d     = state_q;
        scr_cnt_d   = scr_cnt_q;
        cnt_d       = cnt_q;
        undo_pend_d = undo_pend_q;
        eng_face    = 6'd0;
        eng_rot     = 3'd0;
        commit      = 1'b0;
        push_hist   = 1'b0;
        pop_hist    = 1'b0;
        clr_hist    = 1'b0;
        verify      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (scr_start) begin
                    state_d = S_SCR_INIT;
                end else if (undo_pend_q) begin
                    state_d = S_UNDO;
                end else if (!fifo_empty) begin
                    state_d = S_APPLY;
                end
            end
            S_SCR_INIT: begin
                clr_hist  = 1'b1;
                cnt_d     = 10'd0;
                scr_cnt_d = 6'd0;
                state_d   = S_SCRAMBLE;
            end
            S_SCRAMBLE: begin
                eng_face = {3'b000, rnd_face};
                eng_rot  = {1'b0, rnd_map};
                // A "none" draw is retried next cycle without consuming a slot.
                if (rnd_map != 2'd0) begin
                    commit    = 1'b1;
                    scr_cnt_d = scr_cnt_q + 6'd1;
                    if (scr_cnt_q == SCR_LAST) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_APPLY: begin
                eng_face  = {3'b000, head[4:2]};
                eng_rot   = {1'b0, head[1:0]};
                commit    = 1'b1;
                push_hist = !hist_full;
                cnt_d     = (cnt_q >= CNT_TOP) ? cnt_q : cnt_q + 10'd1;
                state_d   = S_VERIFY;
            end
            S_UNDO: begin
                undo_pend_d = 1'b0;
                if (!hist_empty) begin
                    pop_hist = 1'b1;
                    cnt_d    = (cnt_q != 10'd0) ? cnt_q - 10'd1 : cnt_q;
                    state_d  = S_VERIFY;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_VERIFY: begin
                verify  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A fresh request arriving while one is serviced stays pending.
        if (undo_req && (state_q != S_SCRAMBLE)) begin
            undo_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            scr_cnt_q   <= 6'd0;
            cnt_q       <= 10'd0;
            undo_pend_q <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
        end else begin
            state_q     <= state_d;
            scr_cnt_q   <= scr_cnt_d;
            cnt_q       <= cnt_d;
            undo_pend_q <= undo_pend_d;
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (rd_en) rd_q <= rd_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler; inputs change and outputs are sampled near negedge.
module tb_move_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       man_valid, man_ready;
    logic [2:0] man_face;
    logic [1:0] man_rot;
    logic       scr_start;
    logic [2:0] rnd_face;
    logic [1:0] rnd_rot;
    logic       undo_req, hist_empty, hist_full;
    logic [5:0] eng_face;
    logic [2:0] eng_rot;
    logic       commit, push_hist, pop_hist, clr_hist, verify, busy;
    logic [9:0] move_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    move_scheduler #(.QDEPTH(4), .SCRAMBLE_LEN(20), .CNT_MAX(999)) dut (
        .clk(clk), .rst(rst),
        .man_valid(man_valid), .man_ready(man_ready), .man_face(man_face), .man_rot(man_rot),
        .scr_start(scr_start), .rnd_face(rnd_face), .rnd_rot(rnd_rot),
        .undo_req(undo_req), .hist_empty(hist_empty), .hist_full(hist_full),
        .eng_face(eng_face), .eng_rot(eng_rot), .commit(commit),
        .push_hist(push_hist), .pop_hist(pop_hist), .clr_hist(clr_hist),
        .verify(verify), .busy(busy), .move_count(move_count)
    );

    task automatic idle_inputs();
        man_valid = 0; man_face = 0; man_rot = 0; scr_start = 0;
        rnd_face = 0; rnd_rot = 0; undo_req = 0; hist_empty = 0; hist_full = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 0;
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    task automatic do_move(input logic [2:0] f, input logic [1:0] r);
        @(negedge clk); man_valid = 1; man_face = f; man_rot = r;
        @(negedge clk); man_valid = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b want 0", busy); end
        n_checks++; if (man_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b want 1", man_ready); end
        n_checks++; if ({commit, push_hist, pop_hist, clr_hist, verify} !== 5'b0) begin n_fail++; $display("FAIL rst_strobes: got %b want 00000", {commit, push_hist, pop_hist, clr_hist, verify}); end
        n_checks++; if (move_count !== 10'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", move_count); end
        n_checks++; if ({eng_face, eng_rot} !== 9'd0) begin n_fail++; $display("FAIL rst_eng: got %0d/%0d want 0/0", eng_face, eng_rot); end
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    task automatic test_single_move();
        @(negedge clk); man_valid = 1; man_face = 3'd2; man_rot = 2'b01;
        #1;
        n_checks++; if (man_ready !== 1'b1) begin n_fail++; $display("FAIL t1_ready: got %0b want 1", man_ready); end
        @(negedge clk); man_valid = 0; #1;
        n_checks++; if (commit !== 1'b0) begin n_fail++; $display("FAIL t1_early_commit: got %0b want 0", commit); end
        @(negedge clk); #1;
        n_checks++; if (commit !== 1'b1) begin n_fail++; $display("FAIL t1_commit: got %0b want 1", commit); end
        n_checks++; if (eng_face !== 6'd2) begin n_fail++; $display("FAIL t1_face: got %0d want 2", eng_face); end
        n_checks++; if (eng_rot !== 3'd1) begin n_fail++; $display("FAIL t1_rot: got %0d want 1", eng_rot); end
        n_checks++; if (push_hist !== 1'b1) begin n_fail++; $display("FAIL t1_push: got %0b want 1", push_hist); end
        @(negedge clk); #1;
        n_checks++; if (verify !== 1'b1) begin n_fail++; $display("FAIL t1_verify: got %0b want 1", verify); end
        n_checks++; if (commit !== 1'b0) begin n_fail++; $display("FAIL t1_commit_drop: got %0b want 0", commit); end
        n_checks++; if (move_count !== 10'd1) begin n_fail++; $display("FAIL t1_count: got %0d want 1", move_count); end
        @(negedge clk);
    endtask

    task automatic test_fifo_full();
        logic [1:0] rots [5];
        logic [2:0] exp_rot [4];
        int scr_commits, n_man;
        int t_man [4];
        logic [5:0] f_man [4];
        logic [2:0] r_man [4];
        rots = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
        exp_rot = '{3'd1, 3'd3, 3'd2, 3'd1};
        @(negedge clk); rnd_rot = 2'd3; scr_start = 1;
        @(negedge clk); scr_start = 0; #1;
        n_checks++; if (clr_hist !== 1'b1) begin n_fail++; $display("FAIL t2_clr: got %0b want 1", clr_hist); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); man_valid = 1; man_face = 3'(i); man_rot = rots[i]; #1;
            n_checks++; if (man_ready !== (i < 4)) begin n_fail++; $display("FAIL t2_ready_%0d: got %0b want %0b", i, man_ready, (i < 4)); end
        end
        @(negedge clk); man_valid = 0; #1;
        n_checks++; if ({man_ready, busy, commit} !== 3'b010) begin n_fail++; $display("FAIL t2_held: ready/busy/commit got %b want 010", {man_ready, busy, commit}); end
        rnd_rot = 2'd0; rnd_face = 3'd5; #1;
        scr_commits = 0;
        for (int j = 0; j < 40; j++) begin
            if (busy == 1'b0) break;
            if (commit) scr_commits++;
            @(negedge clk); #1;
        end
        n_checks++; if (scr_commits != 20) begin n_fail++; $display("FAIL t2_burst: got %0d commits want 20", scr_commits); end
        n_man = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (commit) begin
                if (n_man < 4) begin t_man[n_man] = k; f_man[n_man] = eng_face; r_man[n_man] = eng_rot; end
                n_man++;
            end
        end
        n_checks++; if (n_man != 4) begin n_fail++; $display("FAIL t2_man_commits: got %0d want 4", n_man); end
        for (int m = 0; m < 4 && m < n_man; m++) begin
            n_checks++; if (t_man[m] != 3 * m) begin n_fail++; $display("FAIL t2_spacing_%0d: got cycle %0d want %0d", m, t_man[m], 3 * m); end
            n_checks++; if ({f_man[m], r_man[m]} !== {6'(m), exp_rot[m]}) begin n_fail++; $display("FAIL t2_order_%0d: got face %0d rot %0d want %0d/%0d", m, f_man[m], r_man[m], m, exp_rot[m]); end
        end
        n_checks++; if (move_count !== 10'd4) begin n_fail++; $display("FAIL t2_count: got %0d want 4", move_count); end
    endtask

    task automatic test_scramble();
        logic [1:0] pat [4];
        logic [2:0] pmap [4];
        int commits;
        pat  = '{2'd0, 2'd3, 2'd1, 2'd2};
        pmap = '{3'd1, 3'd0, 3'd3, 3'd2};
        @(negedge clk); scr_start = 1;
        @(negedge clk); scr_start = 0; #1;
        n_checks++; if (clr_hist !== 1'b1) begin n_fail++; $display("FAIL t3_clr: got %0b want 1", clr_hist); end
        commits = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); rnd_rot = pat[i % 4]; rnd_face = 3'(i % 6); undo_req = (i == 2); #1;
            n_checks++; if (commit !== (pat[i % 4] != 2'd3)) begin n_fail++; $display("FAIL t3_commit_%0d: got %0b want %0b", i, commit, (pat[i % 4] != 2'd3)); end
            if (commit) begin
                commits++;
                n_checks++; if ({eng_face, eng_rot} !== {6'(i % 6), pmap[i % 4]}) begin n_fail++; $display("FAIL t3_eng_%0d: got %0d/%0d want %0d/%0d", i, eng_face, eng_rot, i % 6, pmap[i % 4]); end
            end
            if (commits == 20) break;
        end
        undo_req = 0;
        n_checks++; if (commits != 20) begin n_fail++; $display("FAIL t3_len: got %0d want 20", commits); end
        @(negedge clk); #1;
        n_checks++; if ({busy, commit} !== 2'b00) begin n_fail++; $display("FAIL t3_done: busy/commit got %b want 00", {busy, commit}); end
        n_checks++; if (move_count !== 10'd0) begin n_fail++; $display("FAIL t3_count: got %0d want 0", move_count); end
        @(negedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t3_undo_dropped: busy got %0b want 0", busy); end
    endtask

    task automatic test_undo();
        do_reset();
        do_move(3'd1, 2'b01); do_move(3'd2, 2'b10); do_move(3'd3, 2'b11);
        n_checks++; if (move_count !== 10'd3) begin n_fail++; $display("FAIL t4_pre: got %0d want 3", move_count); end
        hist_empty = 0;
        @(negedge clk); undo_req = 1;
        @(negedge clk); undo_req = 0; #1;
        n_checks++; if (pop_hist !== 1'b0) begin n_fail++; $display("FAIL t4_early_pop: got %0b want 0", pop_hist); end
        @(negedge clk); #1;
        n_checks++; if ({pop_hist, commit} !== 2'b10) begin n_fail++; $display("FAIL t4_pop: pop/commit got %b want 10", {pop_hist, commit}); end
        @(negedge clk); #1;
        n_checks++; if ({verify, pop_hist} !== 2'b10) begin n_fail++; $display("FAIL t4_verify: verify/pop got %b want 10", {verify, pop_hist}); end
        n_checks++; if (move_count !== 10'd2) begin n_fail++; $display("FAIL t4_dec: got %0d want 2", move_count); end
        @(negedge clk); hist_empty = 1;
        @(negedge clk); undo_req = 1;
        @(negedge clk); undo_req = 0;
        @(negedge clk); #1;
        n_checks++; if ({busy, pop_hist, commit, verify} !== 4'b1000) begin n_fail++; $display("FAIL t4_empty_undo: busy/pop/commit/verify got %b want 1000", {busy, pop_hist, commit, verify}); end
        @(negedge clk); #1;
        n_checks++; if ({busy, verify} !== 2'b00) begin n_fail++; $display("FAIL t4_empty_idle: busy/verify got %b want 00", {busy, verify}); end
        n_checks++; if (move_count !== 10'd2) begin n_fail++; $display("FAIL t4_count_kept: got %0d want 2", move_count); end
        hist_empty = 0;
    endtask

    task automatic test_saturate();
        int stray;
        do_reset();
        hist_full = 1;
        man_valid = 1; man_face = 3'd3; man_rot = 2'b01;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (move_count == 10'd999) break;
        end
        man_valid = 0;
        n_checks++; if (move_count !== 10'd999) begin n_fail++; $display("FAIL t5_reach: got %0d want 999", move_count); end
        repeat (20) @(negedge clk);
        n_checks++; if ({busy, move_count} !== {1'b0, 10'd999}) begin n_fail++; $display("FAIL t5_drain: busy %0b count %0d want 0/999", busy, move_count); end
        @(negedge clk); man_valid = 1; man_face = 3'd4; man_rot = 2'b10;
        @(negedge clk); man_valid = 0;
        @(negedge clk); #1;
        n_checks++; if ({commit, push_hist, eng_rot} !== {1'b1, 1'b0, 3'd3}) begin n_fail++; $display("FAIL t5_commit: commit/push/rot got %b want 1_0_011", {commit, push_hist, eng_rot}); end
        @(negedge clk); #1;
        n_checks++; if ({verify, move_count} !== {1'b1, 10'd999}) begin n_fail++; $display("FAIL t5_sat: verify %0b count %0d want 1/999", verify, move_count); end
        @(negedge clk); man_valid = 1; man_rot = 2'b00; #1;
        n_checks++; if (man_ready !== 1'b1) begin n_fail++; $display("FAIL t5_null_ready: got %0b want 1", man_ready); end
        @(negedge clk); man_valid = 0;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (commit || busy) stray++;
        end
        n_checks++; if (stray != 0) begin n_fail++; $display("FAIL t5_null_move: got %0d active cycles want 0", stray); end
        hist_full = 0;
    endtask

    task automatic test_reset_mid_scramble();
        int commits, stray;
        @(negedge clk); rnd_rot = 2'd0; rnd_face = 3'd1; scr_start = 1;
        @(negedge clk); scr_start = 0;
        commits = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); man_valid = (i == 0); man_face = 3'd2; man_rot = 2'b01; #1;
            if (commit) commits++;
            if (commits == 7) break;
        end
        rst = 0; #1;
        n_checks++; if ({commit, push_hist, pop_hist, clr_hist, verify, busy} !== 6'b0) begin n_fail++; $display("FAIL t6_strobes: got %b want 000000", {commit, push_hist, pop_hist, clr_hist, verify, busy}); end
        n_checks++; if ({eng_face, eng_rot, move_count} !== 19'd0) begin n_fail++; $display("FAIL t6_data: face %0d rot %0d count %0d want 0", eng_face, eng_rot, move_count); end
        n_checks++; if (man_ready !== 1'b1) begin n_fail++; $display("FAIL t6_ready: got %0b want 1", man_ready); end
        man_valid = 0;
        @(negedge clk); rst = 1;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (commit || busy) stray++;
        end
        n_checks++; if (stray != 0) begin n_fail++; $display("FAIL t6_fifo_flushed: got %0d active cycles want 0", stray); end
        @(negedge clk); scr_start = 1;
        @(negedge clk); scr_start = 0;
        commits = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (commit) commits++;
        end
        n_checks++; if ({busy, commits} !== {1'b0, 32'd20}) begin n_fail++; $display("FAIL t6_new_burst: busy %0b commits %0d want 0/20", busy, commits); end
    endtask

    initial begin
        test_reset();
        test_single_move();
        test_fifo_full();
        test_scramble();
        test_undo();
        test_saturate();
        test_reset_mid_scramble();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, %0d checks done", n_checks);
        $fatal(1);
    end

endmodule
